cla_operand_stage: RTL and testbench

// - Registered input stage for the recursive-doubling CLA: accepts operand pairs on a valid/ready handshake.
// - Encodes each bit pair into generate/propagate form and presents the vectors to the carry-finder and final-sum logic downstream.
// - A 2-entry skid buffer sustains full throughput and isolates upstream timing from downstream back-pressure.
// - Tags each accepted pair with a wrapping sequence number.

---
 rtl/cla_pkg.sv | 34 +++
 rtl/cla_gpk_encode.sv | 24 ++
 rtl/cla_operand_stage.sv | 125 ++++++++++++
 tb/tb_cla_operand_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the CLA operand stage and the carry-finder side.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package cla_pkg;

  localparam int CLA_WIDTH = 8;
  localparam int CLA_SEQ_W = 4;

  // Per-bit {gen,prop} code; the carry-finder decodes the same values.
  typedef logic [1:0] gpk_t;
  localparam gpk_t GPK_KILL = 2'b00;
  localparam gpk_t GPK_PROP = 2'b01;
  localparam gpk_t GPK_GEN  = 2'b10;

  // Occupancy of the main/skid pair.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_FULL  = 2'b10
  } buf_state_t;

  // Classifies one bit pair; gen and prop are mutually exclusive by construction.
  function automatic gpk_t gpk_of(input logic a, input logic b);
    gpk_t code;
    if (a && b)
      code = GPK_GEN;
    else if (a || b)
      code = GPK_PROP;
    else
      code = GPK_KILL;
    return code;
  endfunction

endpackage

// File: rtl/cla_gpk_encode.sv
// Purpose: bitwise generate/propagate encoding of an operand pair.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of a and b.
module cla_gpk_encode
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] gen,
  output logic [WIDTH-1:0] prop
);

  // Split each bit's {gen,prop} code onto the two output vectors.
  always_comb begin
    gen  = '0;
    prop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {gen[i], prop[i]} = gpk_of(a[i], b[i]);
    end
  end

endmodule

// File: rtl/cla_operand_stage.sv
// Purpose: registered gen/prop input stage with a 2-entry skid buffer and sequence tags.
// Latency: 1 cycle from accept to out_valid; 1 pair/cycle sustained.
// Backpressure: skid absorbs one pair on out_ready=0; in_ready drops while the skid is full.
module cla_operand_stage
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int SEQ_W = CLA_SEQ_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gen,
  output logic [WIDTH-1:0] out_prop,
  output logic [SEQ_W-1:0] out_seq
);

  logic [WIDTH-1:0] enc_gen, enc_prop;
  logic [WIDTH-1:0] main_gen, main_prop, skid_gen, skid_prop;
  logic [SEQ_W-1:0] main_seq, skid_seq, seq_cnt;
  logic             run_en;
  buf_state_t       state, state_nxt;
  logic             ld_main_in, ld_main_skid, ld_skid;
  logic             accept;

  // Encode ahead of the flops so out_* is driven purely from registers.
  cla_gpk_encode #(.WIDTH(WIDTH)) u_encode (
    .a    (in_a),
    .b    (in_b),
    .gen  (enc_gen),
    .prop (enc_prop)
  );

  // in_ready is flop-only: the enable flop and the skid-occupied state bit.
  assign in_ready  = run_en && (state != BUF_FULL);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state != BUF_EMPTY);
  assign out_gen   = main_gen;
  assign out_prop  = main_prop;
  assign out_seq   = main_seq;

  // One-flop enable: hold off upstream until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_en <= 1'b0;
    else        run_en <= 1'b1;
  end

  // Tag counter advances per accepted pair and wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      seq_cnt <= '0;
    else if (accept) seq_cnt <= seq_cnt + 1'b1;
  end

  // Buffer occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BUF_EMPTY;
    else        state <= state_nxt;
  end

  // Next occupancy and which register loads from where.
  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state)
      BUF_EMPTY: begin
        if (accept) begin
          ld_main_in = 1'b1;
          state_nxt  = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (accept && out_ready) begin
          ld_main_in = 1'b1;
        end else if (accept) begin
          ld_skid   = 1'b1;
          state_nxt = BUF_FULL;
        end else if (out_ready) begin
          state_nxt = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (out_ready) begin
          ld_main_skid = 1'b1;
          state_nxt    = BUF_ONE;
        end
      end
      default: state_nxt = BUF_EMPTY;
    endcase
  end

  // Main/skid payload registers; main holds steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_gen  <= '0;
      main_prop <= '0;
      main_seq  <= '0;
      skid_gen  <= '0;
      skid_prop <= '0;
      skid_seq  <= '0;
    end else begin
      if (ld_main_in) begin
        main_gen  <= enc_gen;
        main_prop <= enc_prop;
        main_seq  <= seq_cnt;
      end else if (ld_main_skid) begin
        main_gen  <= skid_gen;
        main_prop <= skid_prop;
        main_seq  <= skid_seq;
      end
      if (ld_skid) begin
        skid_gen  <= enc_gen;
        skid_prop <= enc_prop;
        skid_seq  <= seq_cnt;
      end
    end
  end

endmodule

// File: tb/tb_cla_operand_stage.sv
module tb_cla_operand_stage;

  localparam int WIDTH = 8;
  localparam int SEQ_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_gen;
  logic [WIDTH-1:0] out_prop;
  logic [SEQ_W-1:0] out_seq;

  cla_operand_stage #(.WIDTH(WIDTH), .SEQ_W(SEQ_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gen   (out_gen),
    .out_prop  (out_prop),
    .out_seq   (out_seq)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] gen;
    logic [7:0] prop;
  } vec_t;

  typedef struct {
    logic [7:0] gen;
    logic [7:0] prop;
    int         seq;
  } exp_t;

  vec_t vecs[7];
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sbq.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] sa[64];
    logic [7:0] sb[64];
    int acc, popped, cyc, nseq;
    exp_t e;

    // Expected encodings worked out by hand: gen = a&b, prop = a^b.
    vecs[0] = '{8'hF0, 8'hCC, 8'hC0, 8'h3C};
    vecs[1] = '{8'hFF, 8'h01, 8'h01, 8'hFE};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
    vecs[4] = '{8'hAA, 8'h55, 8'h00, 8'hFF};
    vecs[5] = '{8'h0F, 8'h3C, 8'h0C, 8'h33};
    vecs[6] = '{8'h12, 8'h34, 8'h10, 8'h26};

    // ---- reset release ----
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_gen",   out_gen, 0);
    chk("rst_out_prop",  out_prop, 0);
    chk("rst_out_seq",   out_seq, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_before_edge", in_ready, 0);
    @(negedge clk);
    chk("rel_in_ready_after_edge", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    // ---- table-driven encoding, out_ready=1 ----
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a = vecs[0].a;
    in_b = vecs[0].b;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("vec_out_valid", out_valid, 1);
      chk("vec_gen",  out_gen,  vecs[i].gen);
      chk("vec_prop", out_prop, vecs[i].prop);
      chk("vec_seq",  out_seq,  i);
      chk("vec_in_ready", in_ready, 1);
      if (i < 6) begin
        in_a = vecs[i+1].a;
        in_b = vecs[i+1].b;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("vec_drained", out_valid, 0);

    // ---- back-pressure: three pairs, out_ready=0 ----
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22;
    @(negedge clk);
    chk("bp_p0_valid", out_valid, 1);
    chk("bp_p0_gen", out_gen, 8'h00);
    chk("bp_p0_prop", out_prop, 8'h33);
    chk("bp_p0_seq", out_seq, 0);
    chk("bp_in_ready_after1", in_ready, 1);
    in_a = 8'hF3; in_b = 8'h35;
    @(negedge clk);
    chk("bp_in_ready_after2", in_ready, 0);
    chk("bp_stall_gen", out_gen, 8'h00);
    chk("bp_stall_prop", out_prop, 8'h33);
    chk("bp_stall_seq", out_seq, 0);
    in_a = 8'h0E; in_b = 8'h07;
    @(negedge clk);
    chk("bp_held_in_ready", in_ready, 0);
    chk("bp_stall2_prop", out_prop, 8'h33);
    chk("bp_stall2_seq", out_seq, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_p1_gen", out_gen, 8'h31);
    chk("bp_p1_prop", out_prop, 8'hC6);
    chk("bp_p1_seq", out_seq, 1);
    chk("bp_in_ready_reopen", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_p2_valid", out_valid, 1);
    chk("bp_p2_gen", out_gen, 8'h06);
    chk("bp_p2_prop", out_prop, 8'h09);
    chk("bp_p2_seq", out_seq, 2);
    @(negedge clk);
    chk("bp_drained", out_valid, 0);

    // ---- streaming 64 random pairs ----
    do_reset();
    for (int i = 0; i < 64; i++) begin
      sa[i] = 8'($urandom);
      sb[i] = 8'($urandom);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a = sa[0];
    in_b = sb[0];
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("str_valid", out_valid, 1);
      chk("str_gen",   out_gen,  sa[i] & sb[i]);
      chk("str_prop",  out_prop, sa[i] ^ sb[i]);
      chk("str_seq",   out_seq,  i % 16);
      chk("str_in_ready", in_ready, 1);
      if (i < 63) begin
        in_a = sa[i+1];
        in_b = sb[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end

    // ---- random valid/ready, scoreboard ----
    do_reset();
    acc = 0; popped = 0; cyc = 0; nseq = 0;
    while ((acc < 1000 || sbq.size() > 0) && cyc < 20000) begin
      chk("rnd_out_valid", out_valid, sbq.size() > 0);
      chk("rnd_in_ready",  in_ready,  sbq.size() < 2);
      in_valid  = (acc < 1000) && ($urandom_range(0, 3) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      out_ready = (acc >= 1000) || ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready && sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("rnd_gen",  out_gen,  e.gen);
        chk("rnd_prop", out_prop, e.prop);
        chk("rnd_seq",  out_seq,  e.seq);
        chk("rnd_gen_and_prop", out_gen & out_prop, 0);
        popped++;
      end
      if (in_valid && in_ready) begin
        sbq.push_back('{in_a & in_b, in_a ^ in_b, nseq % 16});
        nseq++;
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("rnd_accepted", acc, 1000);
    chk("rnd_delivered", popped, 1000);
    chk("rnd_empty_after", out_valid, 0);

    // ---- reset while FULL ----
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h5A;
    @(negedge clk);
    in_a = 8'h77; in_b = 8'h88;
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 0);
    chk("async_out_gen", out_gen, 0);
    chk("async_out_prop", out_prop, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready_low", in_ready, 0);
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_no_stale", out_valid, 0);
    in_valid = 1'b1; in_a = 8'h3C; in_b = 8'h0F;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_gen", out_gen, 8'h0C);
    chk("post_rst_prop", out_prop, 8'h33);
    chk("post_rst_seq", out_seq, 0);
    @(negedge clk);
    chk("post_rst_drained", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
